locker_lockout_ctrl: RTL

- Downstream stage of the door-code FSM in the digital locker.
- Consumes its LED_right / LED_wrong verdict outputs and drives the physical door-open line, a buzzer pattern and an entry-enable back to the keypad path.
- Counts consecutive wrong attempts; after MAX_FAILS wrong attempts it enforces a timed lockout.
- A correct attempt opens the door for a timed window, then relocks automatically.

---
 rtl/locker_lockout_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/locker_lockout_ctrl.sv
// Locker lockout controller: turns door-FSM verdicts into door, buzzer
// and keypad-enable drive, with a wrong-attempt counter and timed lockout.
module locker_lockout_ctrl #(
  parameter int MAX_FAILS     = 3,
  parameter int FAIL_W        = 2,
  parameter int UNLOCK_CYCLES = 500,
  parameter int WARN_CYCLES   = 50,
  parameter int LOCK_CYCLES   = 5000,
  parameter int BEEP_HALF     = 25,
  parameter int TMR_W         = 13
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              LED_right,
  input  logic              LED_wrong,
  input  logic              lock_req,
  output logic              door_open,
  output logic              entry_enable,
  output logic              buzzer,
  output logic [FAIL_W-1:0] fail_count,
  output logic [1:0]        mode
);

  localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    WARN     = 2'd2,
    LOCKOUT  = 2'd3
  } mode_e;

  mode_e             state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic              tone_q, tone_d;
  logic              right_q, right_d;
  logic              wrong_q, wrong_d;
  logic              door_q, door_d;
  logic              entry_q, entry_d;
  logic              buzz_q, buzz_d;
  logic              right_evt, wrong_evt;

  assign right_evt = LED_right & ~right_q;
  assign wrong_evt = LED_wrong & ~wrong_q;

  // Next-state, timer, fail counter and lockout tone phase
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    beep_d  = beep_q;
    tone_d  = tone_q;
    right_d = LED_right;
    wrong_d = LED_wrong;
    unique case (state_q)
      IDLE: begin
        if (wrong_evt) begin
          if (int'(fail_q) + 1 < MAX_FAILS) begin
            state_d = WARN;
            fail_d  = fail_q + 1'b1;
            timer_d = TMR_W'(WARN_CYCLES - 1);
          end else begin
            state_d = LOCKOUT;
            fail_d  = FAIL_W'(MAX_FAILS);
            timer_d = TMR_W'(LOCK_CYCLES - 1);
            beep_d  = '0;
            tone_d  = 1'b1;
          end
        end else if (right_evt) begin
          state_d = UNLOCKED;
          fail_d  = '0;
          timer_d = TMR_W'(UNLOCK_CYCLES - 1);
        end
      end
      UNLOCKED: begin
        if (lock_req || timer_q == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WARN: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
          beep_d  = '0;
          tone_d  = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
          if (beep_q == BEEP_W'(BEEP_HALF - 1)) begin
            beep_d = '0;
            tone_d = ~tone_q;
          end else begin
            beep_d = beep_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    door_d  = (state_d == UNLOCKED);
    entry_d = (state_d == IDLE);
    buzz_d  = (state_d == WARN) |
              ((state_d == LOCKOUT) & tone_d);
  end

  // State and output registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      fail_q  <= '0;
      beep_q  <= '0;
      tone_q  <= 1'b0;
      right_q <= 1'b0;
      wrong_q <= 1'b0;
      door_q  <= 1'b0;
      entry_q <= 1'b1;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      beep_q  <= beep_d;
      tone_q  <= tone_d;
      right_q <= right_d;
      wrong_q <= wrong_d;
      door_q  <= door_d;
      entry_q <= entry_d;
      buzz_q  <= buzz_d;
    end
  end

  assign door_open    = door_q;
  assign entry_enable = entry_q;
  assign buzzer       = buzz_q;
  assign fail_count   = fail_q;
  assign mode         = state_q;

endmodule
